// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - command/response sequencer that drives an external ALU and captures its result
//
// Parameters:
//   WIDTH  - operand/result width
//   SETTLE - cycles the operands sit on the ALU ports before the result is captured (1..15)
//
// Ports:
//   clk, rst_n                  - clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready         - command handshake; cmd_a, cmd_b, cmd_op carry the command
//   alu_A, alu_B, alu_op        - registered drive to the ALU, held until the next legal command
//   alu_v_out, alu_z            - ALU result and zero flag
//   rsp_valid/rsp_ready         - response handshake; rsp_data, rsp_z, rsp_err carry the response
//   stat_cmds, stat_zero        - only with ALU_DRIVER_STATS_EN: accepted-command and zero-result counters
//
// Optional feature macro: ALU_DRIVER_STATS_EN
module alu_driver #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_v_out,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
`ifdef ALU_DRIVER_STATS_EN
    output logic [15:0]      stat_cmds,
    output logic [15:0]      stat_zero,
`endif
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_err_q, rsp_err_d;
    logic             accept;
    logic             capture;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_z_d    = rsp_z_q;
        rsp_err_d  = rsp_err_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SETTLE;
                    if (cmd_op <= 3'd5) begin
                        alu_a_d   = cmd_a;
                        alu_b_d   = cmd_b;
                        alu_op_d  = cmd_op;
                        cnt_d     = SETTLE_LOAD;
                        illegal_d = 1'b0;
                    end else begin
                        // Illegal op leaves the ALU drive untouched and skips the
                        // settle window: a zero count gives a one-cycle turnaround.
                        cnt_d     = 4'd0;
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (illegal_q) begin
                        rsp_data_d = '0;
                        rsp_z_d    = 1'b0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        rsp_data_d = alu_v_out;
                        rsp_z_d    = alu_z;
                        rsp_err_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                // Returning to IDLE (not accepting here) forces the one-cycle bubble.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            illegal_q  <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= 3'd0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_z_q    <= rsp_z_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef ALU_DRIVER_STATS_EN
    logic [15:0] stat_cmds_q, stat_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cmds_q <= 16'd0;
            stat_zero_q <= 16'd0;
        end else begin
            if (accept) begin
                stat_cmds_q <= stat_cmds_q + 16'd1;
            end
            if (capture && alu_z) begin
                stat_zero_q <= stat_zero_q + 16'd1;
            end
        end
    end

    assign stat_cmds = stat_cmds_q;
    assign stat_zero = stat_zero_q;
`else
    // Keeps the strobes referenced when the counters are compiled out.
    logic unused_stats;
    assign unused_stats = accept ^ capture;
`endif

    assign alu_A    = alu_a_q;
    assign alu_B    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign rsp_data = rsp_data_q;
    assign rsp_z    = rsp_z_q;
    assign rsp_err  = rsp_err_q;

endmodule
